// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, opcodes and instruction-type encodings shared by the front end and pipeline
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    typedef enum logic [5:0] {
        OP_ADD  = 6'b000000,
        OP_SUB  = 6'b000001,
        OP_AND  = 6'b000010,
        OP_OR   = 6'b000011,
        OP_XOR  = 6'b000100,
        OP_ADDI = 6'b000101,
        OP_SLI  = 6'b000110,
        OP_SRI  = 6'b000111,
        OP_BNE  = 6'b001000
    } opcode_e;
    typedef enum logic [1:0] {ITYPE_R, ITYPE_I, ITYPE_B} itype_e;
    function automatic opcode_e opcode_of(input logic [DATA_W-1:0] instr);
        return opcode_e'(instr[DATA_W-1:DATA_W-6]);
    endfunction
    function automatic itype_e itype_of(input opcode_e op);
        return op == OP_BNE ? ITYPE_B : (op >= OP_ADDI ? ITYPE_I : ITYPE_R);
    endfunction
endpackage

// File: rtl/instr_prefetch_unit_if.sv
// instr_prefetch_unit_if: in-order instruction memory read bus (request/grant, ordered responses)
interface instr_prefetch_unit_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH-entry in-order queue with synchronous flush; push while full is allowed with a pop
module sync_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 4
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign dout    = mem[rp];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk1) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: issues ordered imem reads, queues {instr, pc+1}, flushes and drops stale replies on redirect
module instr_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int                 DATA_W   = cpu_pkg::DATA_W,
    parameter int                 ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                  clk1,
    input  logic                  rst,
    instr_prefetch_unit_if.master imem,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic                  ir_valid,
    output logic [DATA_W-1:0]     ir,
    output logic [ADDR_W-1:0]     npc,
    input  logic                  ir_ready,
    output logic                  busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [ADDR_W-1:0]        fetch_pc, ret_pc;
    logic [CW-1:0]            outstanding, discard, count, out_next;
    logic                     issue, accept, full, empty;
    logic [DATA_W+ADDR_W-1:0] head;
    // count + outstanding never exceeds DEPTH, so every granted reply has a free slot
    assign imem.req  = !rst && !redirect_valid && (count + outstanding < CW'(DEPTH));
    assign imem.addr = fetch_pc;
    assign issue     = imem.req && imem.gnt;
    assign accept    = imem.rvalid && discard == '0 && !redirect_valid;
    assign out_next  = outstanding + CW'(issue) - CW'(imem.rvalid);
    assign ir_valid  = !empty;
    assign {ir, npc} = empty ? '0 : head;
    assign busy      = outstanding != '0 || discard != '0;
    sync_fifo #(.W(DATA_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
        .clk1  (clk1),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (accept),
        .pop   (ir_valid && ir_ready),
        .din   ({imem.rdata, ret_pc + ADDR_W'(1)}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk1) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            ret_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            assert (!(accept && full));
            outstanding <= out_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                ret_pc   <= redirect_pc;
                discard  <= out_next;
            end else begin
                if (issue) fetch_pc <= fetch_pc + ADDR_W'(1);
                if (accept) ret_pc <= ret_pc + ADDR_W'(1);
                if (imem.rvalid && discard != '0) discard <= discard - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb_instr_prefetch_unit: directed checks of streaming, backpressure, redirects, PC wrap and mid-stream reset
module tb_instr_prefetch_unit;
    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        ir_ready = 1'b0;
    logic        ir_valid;
    logic [31:0] ir;
    logic [9:0]  npc;
    logic        busy;
    int          n_chk = 0;
    int          n_fail = 0;
    int          lat = 1;
    int          cyc = 0;
    typedef struct {logic [9:0] a; int due;} pend_t;
    pend_t       pend[$];

    instr_prefetch_unit_if bus ();

    instr_prefetch_unit dut (
        .clk1           (clk1),
        .rst            (rst),
        .imem           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .npc            (npc),
        .ir_ready       (ir_ready),
        .busy           (busy)
    );

    always #5 clk1 = ~clk1;

    // in-order memory, Mem[k] = k, reply `lat` cycles after the grant cycle
    always @(posedge clk1) begin
        cyc <= cyc + 1;
        if (rst) begin
            pend.delete();
            bus.rvalid <= 1'b0;
        end else begin
            if (bus.req && bus.gnt) pend.push_back('{bus.addr, cyc + lat - 1});
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= {22'd0, pend[0].a};
                void'(pend.pop_front());
            end else begin
                bus.rvalid <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        lat = l;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.gnt  = 1'b1;
        ir_ready = 1'b1;
        tick();
        tick();
        chk("rst_ir_valid", 32'(ir_valid), 0);
        chk("rst_ir", ir, 0);
        chk("rst_npc", 32'(npc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req", 32'(bus.req), 0);
        rst = 1'b0;
        #1;
        chk("d0_req", 32'(bus.req), 1);
        chk("d0_addr", 32'(bus.addr), 0);
        tick();
        chk("d1_ir_valid", 32'(ir_valid), 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("seq_valid", 32'(ir_valid), 1);
            chk("seq_ir", ir, 32'(k));
            chk("seq_npc", 32'(npc), 32'(k + 1));
            tick();
        end

        ir_ready = 1'b0;
        repeat (10) tick();
        chk("stall_req", 32'(bus.req), 0);
        chk("stall_busy", 32'(busy), 0);
        chk("stall_valid", 32'(ir_valid), 1);
        chk("stall_ir", ir, 8);
        ir_ready = 1'b1;
        for (int k = 8; k < 16; k++) begin
            chk("drain_valid", 32'(ir_valid), 1);
            chk("drain_ir", ir, 32'(k));
            tick();
        end

        chk("pre_redir_ir", ir, 16);
        redirect_valid = 1'b1;
        redirect_pc    = 10'h155;
        #1;
        chk("redir_req", 32'(bus.req), 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_t1_valid", 32'(ir_valid), 0);
        chk("redir_t1_addr", 32'(bus.addr), 32'h155);
        chk("redir_t1_req", 32'(bus.req), 1);
        chk("redir_t1_busy", 32'(busy), 0);
        tick();
        chk("redir_t2_valid", 32'(ir_valid), 0);
        tick();
        chk("redir_t3_valid", 32'(ir_valid), 1);
        chk("redir_t3_ir", ir, 32'h155);
        chk("redir_t3_npc", 32'(npc), 32'h156);
        tick();
        chk("redir_t4_ir", ir, 32'h156);

        redirect_valid = 1'b1;
        redirect_pc    = 10'h100;
        tick();
        redirect_pc    = 10'd1022;
        #1;
        chk("b2b_valid", 32'(ir_valid), 0);
        chk("b2b_req", 32'(bus.req), 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr0", 32'(bus.addr), 1022);
        chk("wrap_req", 32'(bus.req), 1);
        tick();
        chk("wrap_addr1", 32'(bus.addr), 1023);
        tick();
        chk("wrap_addr2", 32'(bus.addr), 0);
        chk("wrap_ir0", ir, 1022);
        chk("wrap_npc0", 32'(npc), 1023);
        tick();
        chk("wrap_addr3", 32'(bus.addr), 1);
        chk("wrap_ir1", ir, 1023);
        chk("wrap_npc1", 32'(npc), 0);
        tick();
        chk("wrap_ir2", ir, 0);
        chk("wrap_npc2", 32'(npc), 1);
        tick();
        chk("wrap_ir3", ir, 1);
        chk("wrap_npc3", 32'(npc), 2);

        do_reset(3);
        tick();
        tick();
        tick();
        chk("slow_busy", 32'(busy), 1);
        chk("slow_rvalid_seen", 32'(ir_valid), 0);
        redirect_valid = 1'b1;
        redirect_pc    = 10'h200;
        #1;
        chk("slow_redir_req", 32'(bus.req), 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("slow_t1_valid", 32'(ir_valid), 0);
        chk("slow_t1_addr", 32'(bus.addr), 32'h200);
        chk("slow_t1_busy", 32'(busy), 1);
        tick();
        chk("slow_t2_valid", 32'(ir_valid), 0);
        chk("slow_t2_busy", 32'(busy), 1);
        tick();
        chk("slow_t3_valid", 32'(ir_valid), 0);
        tick();
        chk("slow_t4_valid", 32'(ir_valid), 0);
        tick();
        chk("slow_t5_valid", 32'(ir_valid), 1);
        chk("slow_t5_ir", ir, 32'h200);
        chk("slow_t5_npc", 32'(npc), 32'h201);
        tick();
        chk("slow_t6_ir", ir, 32'h201);
        chk("slow_t6_npc", 32'(npc), 32'h202);
        chk("slow_t6_busy", 32'(busy), 1);

        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus.req), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ir_valid), 0);
        chk("mid_rst_ir", ir, 0);
        chk("mid_rst_npc", 32'(npc), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_addr", 32'(bus.addr), 0);
        tick();
        tick();
        tick();
        chk("restart_t3_valid", 32'(ir_valid), 0);
        tick();
        chk("restart_valid", 32'(ir_valid), 1);
        chk("restart_ir", ir, 0);
        chk("restart_npc", 32'(npc), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
